exu_mul_seq: RTL

- Multi-cycle multiply sequencer that sits between the EXU multiplier array and the pipeline control unit.
- When a multiply enters EXU, it holds the pipeline (MulBusy) for a fixed number of EXU cycles and paces the multiplier array (MulStep).
- Signals completion (MulDone), honours MAU stalls by freezing, and aborts cleanly on pipe flush or EXU exception.
- Replaces the ad-hoc shift-register multiply timing inside the PCU with an explicit, verifiable FSM.

---
 rtl/pcu_pkg.sv | 18 +
 rtl/mul_cycle_counter.sv | 34 +++
 rtl/exu_mul_seq.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/pcu_pkg.sv
// Shared PCU/EXU types and constants for multiply sequencing and exception wiring.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pcu_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mul_state_t;

    // Exception code width and the position of its valid bit.
    localparam int EXC_W     = 4;
    localparam int EXC_VALID = 3;

    // Default multiply occupancy in EXU cycles, including the issue cycle.
    localparam int MUL_CYCLES_DEF = 5;

endpackage

// File: rtl/mul_cycle_counter.sv
// Iteration counter for the multiply sequencer; flags the final iteration.
// Latency: count updates one cycle after clear/load1/enable; last is combinational from count.
// Backpressure: holds its value whenever enable is low (MAU freeze); saturates at the final value.
module mul_cycle_counter #(
    parameter int CNT_W      = 3,
    parameter int MUL_CYCLES = 5
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             clear,
    input  logic             load1,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(MUL_CYCLES - 1);

    // Clear beats load beats increment; never step past the final value so the count cannot wrap.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load1) begin
            count <= CNT_W'(1);
        end else if (enable && !last) begin
            count <= count + CNT_W'(1);
        end
    end

    assign last = (count == LAST_VAL);

endmodule

// File: rtl/exu_mul_seq.sv
// Multi-cycle multiply sequencer: holds the pipe (MulBusy) and paces the multiplier array (MulStep).
// Latency: MulStart in cycle 0 gives MulDone in cycle MUL_CYCLES-1; each MAU freeze cycle adds one.
// Backpressure: nMAUNotReady low freezes state and count; flush/exception aborts with a MulAbort pulse.
module exu_mul_seq
    import pcu_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int CNT_W      = 3
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             MulStart,
    input  logic             nMAUNotReady,
    input  logic             nFlushPipe,
    input  logic [EXC_W-1:0] ExceptEXU,
    output logic             MulBusy,
    output logic             MulStep,
    output logic             MulDone,
    output logic             MulAbort,
    output logic [CNT_W-1:0] MulCount,
    output logic             MulErr
);

    // Reject occupancies the counter cannot represent or that leave no room for an iteration.
    if (MUL_CYCLES < 2 || MUL_CYCLES > 2**CNT_W) begin : gBadMulCycles
        $error("exu_mul_seq: MUL_CYCLES out of range 2..2**CNT_W");
    end

    mul_state_t       state;
    mul_state_t       stateNext;
    logic [CNT_W-1:0] count;
    logic             cntLast;
    logic             cntClear;
    logic             cntLoad1;
    logic             cntEnable;
    logic             errSet;
    logic             abortReq;
    logic             busyC;
    logic             stepC;
    logic             doneC;
    logic             abortC;

    // Only the valid bit of the exception code matters here; the cause bits are carried for the PCU.
    logic unusedExcCause;
    assign unusedExcCause = ^ExceptEXU;

    assign abortReq = !nFlushPipe || ExceptEXU[EXC_VALID];

    mul_cycle_counter #(
        .CNT_W      (CNT_W),
        .MUL_CYCLES (MUL_CYCLES)
    ) uCounter (
        .clk    (clk),
        .Reset  (Reset),
        .clear  (cntClear),
        .load1  (cntLoad1),
        .enable (cntEnable),
        .count  (count),
        .last   (cntLast)
    );

    // State register.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next state, counter controls and raw outputs; in RUN, abort beats freeze beats done.
    always_comb begin
        stateNext = state;
        busyC     = 1'b0;
        stepC     = 1'b0;
        doneC     = 1'b0;
        abortC    = 1'b0;
        cntClear  = 1'b0;
        cntLoad1  = 1'b0;
        cntEnable = 1'b0;
        errSet    = 1'b0;
        case (state)
            IDLE: begin
                if (MulStart) begin
                    if (abortReq) begin
                        abortC = 1'b1;
                    end else begin
                        // A start during a freeze issues without stepping; count stays at 0.
                        busyC     = 1'b1;
                        stepC     = nMAUNotReady;
                        cntLoad1  = nMAUNotReady;
                        stateNext = RUN;
                    end
                end
            end
            RUN: begin
                // A new start while running is a PCU protocol error, except in the done cycle.
                errSet = MulStart;
                if (abortReq) begin
                    abortC    = 1'b1;
                    cntClear  = 1'b1;
                    stateNext = IDLE;
                end else if (!nMAUNotReady) begin
                    busyC = 1'b1;
                end else if (cntLast) begin
                    doneC     = 1'b1;
                    stepC     = 1'b1;
                    cntClear  = 1'b1;
                    errSet    = 1'b0;
                    stateNext = IDLE;
                end else begin
                    busyC     = 1'b1;
                    stepC     = 1'b1;
                    cntEnable = 1'b1;
                end
            end
            default: begin
                cntClear  = 1'b1;
                stateNext = IDLE;
            end
        endcase
    end

    // Sticky protocol-error flag, cleared only by reset.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            MulErr <= 1'b0;
        end else if (errSet) begin
            MulErr <= 1'b1;
        end
    end

    // Combinational outputs are forced low while reset is asserted, even with live inputs.
    assign MulBusy  = busyC  && !Reset;
    assign MulStep  = stepC  && !Reset;
    assign MulDone  = doneC  && !Reset;
    assign MulAbort = abortC && !Reset;
    assign MulCount = count;

endmodule
